// File: rtl/div_8_bit_seq.sv
// Sequential restoring divider: one quotient bit per clock, busy/done handshake.
// Define DIV_8_BIT_SIGNED_EN for two's-complement operands (magnitude core plus sign fix-up).
module div_8_bit_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] a_mag, b_mag, q_fin, r_fin;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic             q_bit;
    logic [WIDTH-1:0] step_rem, step_quo;

    // The shifted remainder can reach 2^WIDTH, so the trial subtract carries a spare sign bit.
    assign rem_sh   = {rem_q, dvd_q[WIDTH-1]};
    assign trial    = {1'b0, rem_sh} - {2'b00, dvs_q};
    assign q_bit    = ~trial[WIDTH+1];
    assign step_rem = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign step_quo = {dvd_q[WIDTH-2:0], q_bit};

`ifdef DIV_8_BIT_SIGNED_EN
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    logic sgn_quo_q, sgn_quo_d;
    logic sgn_rem_q, sgn_rem_d;

    assign a_mag = a[WIDTH-1] ? (~a + ONE) : a;
    assign b_mag = b[WIDTH-1] ? (~b + ONE) : b;
    assign q_fin = sgn_quo_q ? (~step_quo + ONE) : step_quo;
    assign r_fin = sgn_rem_q ? (~step_rem + ONE) : step_rem;
`else
    assign a_mag = a;
    assign b_mag = b;
    assign q_fin = step_quo;
    assign r_fin = step_rem;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
`ifdef DIV_8_BIT_SIGNED_EN
        sgn_quo_d = sgn_quo_q;
        sgn_rem_d = sgn_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (b == '0) begin
                        q_d     = '1;
                        r_d     = a;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        dvd_d   = a_mag;
                        dvs_d   = b_mag;
                        rem_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        state_d = RUN;
`ifdef DIV_8_BIT_SIGNED_EN
                        sgn_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
                        sgn_rem_d = a[WIDTH-1];
`endif
                    end
                end
            end
            RUN: begin
                dvd_d = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    q_d     = q_fin;
                    r_d     = r_fin;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV_8_BIT_SIGNED_EN
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
`ifdef DIV_8_BIT_SIGNED_EN
            sgn_quo_q <= sgn_quo_d;
            sgn_rem_q <= sgn_rem_d;
`endif
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign q           = q_q;
    assign r           = r_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_8_bit_seq.sv
// Bench for div_8_bit_seq: per-cycle model comparison plus directed literal vectors and an identity sweep.
module tb_div_8_bit_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] q, r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_8_bit_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .q(q), .r(r), .div_by_zero(div_by_zero)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Arithmetic reference for one division result.
    function automatic void ref_div(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                    output logic [W-1:0] qo, output logic [W-1:0] ro,
                                    output logic dz);
`ifdef DIV_8_BIT_SIGNED_EN
        int ia, ib;
        ia = $signed(ai);
        ib = $signed(bi);
        if (ib == 0) begin
            qo = '1; ro = ai; dz = 1'b1;
        end else if (ia == -(2 ** (W - 1)) && ib == -1) begin
            qo = ai; ro = '0; dz = 1'b0;
        end else begin
            qo = W'(ia / ib); ro = W'(ia % ib); dz = 1'b0;
        end
`else
        if (bi == '0) begin
            qo = '1; ro = ai; dz = 1'b1;
        end else begin
            qo = ai / bi; ro = ai % bi; dz = 1'b0;
        end
`endif
    endfunction

    // Timing model: accept in idle, result WIDTH clocks later, one done cycle, then idle.
    int           m_left = 0;
    bit           m_done = 0;
    logic [W-1:0] m_q = '0, m_r = '0, m_pa = '0, m_pb = '0;
    logic         m_dz = 1'b0;

    always begin
        @(posedge clk);
        if (!rst_n) begin
            m_left = 0; m_done = 0; m_q = '0; m_r = '0; m_dz = 1'b0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                ref_div(m_pa, m_pb, m_q, m_r, m_dz);
                m_done = 1;
            end
        end else if (start) begin
            if (b == '0) begin
                ref_div(a, b, m_q, m_r, m_dz);
                m_done = 1;
            end else begin
                m_left = W; m_pa = a; m_pb = b;
            end
        end
        #1;
        chk("cyc_busy", busy, (m_left > 0) ? 1 : 0);
        chk("cyc_done", done, m_done ? 1 : 0);
        chk("cyc_q", q, m_q);
        chk("cyc_r", r, m_r);
        chk("cyc_dbz", div_by_zero, m_dz);
    end

    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                          output bit seen, output int lat,
                          output logic [W-1:0] gq, output logic [W-1:0] gr, output logic gdz);
        seen = 0; lat = -1; gq = '0; gr = '0; gdz = 1'b0;
        @(negedge clk);
        start = 1'b1; a = ai; b = bi;
        @(posedge clk);
        for (int k = 0; k <= W + 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1; lat = k; gq = q; gr = r; gdz = div_by_zero;
                break;
            end
            @(posedge clk);
        end
        if (seen) @(posedge clk);
    endtask

    task automatic op_lit(input string nm, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        bit seen; int lat; logic [W-1:0] gq, gr; logic gdz;
        run_op(ai, bi, seen, lat, gq, gr, gdz);
        chk({nm, "_done_seen"}, seen, 1);
        chk({nm, "_latency"}, lat, edz ? 0 : W);
        chk({nm, "_q"}, gq, eq);
        chk({nm, "_r"}, gr, er);
        chk({nm, "_dbz"}, gdz, edz);
        $display("op %s a=0x%0h b=0x%0h -> q=0x%0h r=0x%0h dbz=%0d lat=%0d", nm, ai, bi, gq, gr, gdz, lat);
    endtask

    initial begin
        int ndone;
        logic [W-1:0] cq, cr;
        bit seen; int lat; logic [W-1:0] gq, gr; logic gdz;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;

        op_lit("dbz", 8'h5A, 8'h00, 8'hFF, 8'h5A, 1'b1);
        op_lit("b2b_9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0);

        // Abort mid-run: reset takes effect without waiting for a clock.
        @(negedge clk);
        start = 1'b1; a = 8'd200; b = 8'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", q, 0);
        chk("abort_r", r, 0);
        $display("op abort: busy=%0d done=%0d q=0x%0h r=0x%0h", busy, done, q, r);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef DIV_8_BIT_SIGNED_EN
        op_lit("after_abort", 8'd200, 8'd7, 8'hF8, 8'h00, 1'b0);
`else
        op_lit("after_abort", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
`endif

        op_lit("a_lt_b", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
        op_lit("b_one", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        op_lit("a_eq_b", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
        op_lit("a_zero", 8'd0, 8'd17, 8'd0, 8'd0, 1'b0);
`ifdef DIV_8_BIT_SIGNED_EN
        op_lit("s_neg_a", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0);
        op_lit("s_ovf", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
        op_lit("s_neg_b", 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0);
`endif

        // Start pulses during RUN and during DONE must be dropped.
        ndone = 0; cq = '0; cr = '0;
        @(negedge clk);
        start = 1'b1; a = 8'd100; b = 8'd10;
        @(posedge clk);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 3) begin start = 1'b1; a = 8'd1; b = 8'd1; end
            if (done) begin
                ndone++; cq = q; cr = r;
                start = 1'b1; a = 8'd1; b = 8'd1;
            end
        end
        start = 1'b0;
        chk("ign_ndone", ndone, 1);
        chk("ign_q", cq, 10);
        chk("ign_r", cr, 0);
        $display("op ignore_start: dones=%0d q=%0d r=%0d", ndone, cq, cr);

        // Held start: one result every WIDTH+2 clocks.
        ndone = 0;
        @(negedge clk);
        start = 1'b1; a = 8'd9; b = 8'd3;
        for (int k = 0; k < 2 * (W + 2); k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        start = 1'b0;
        chk("held_ndone", ndone, 2);
        $display("op held_start: dones=%0d", ndone);
        repeat (W + 3) @(posedge clk);

        // Identity sweep over a strided dividend set and every divisor.
        for (int ai = 0; ai < 256; ai += 17) begin
            for (int bi = 0; bi < 256; bi++) begin
                run_op(W'(ai), W'(bi), seen, lat, gq, gr, gdz);
                if (!seen) begin
                    chk("sweep_done_seen", 0, 1);
                end else if (bi == 0) begin
                    chk("sweep_dz_q", gq, 255);
                    chk("sweep_dz_r", gr, ai);
                end else begin
`ifdef DIV_8_BIT_SIGNED_EN
                    int iq, ir, ib;
                    logic [W-1:0] recon;
                    iq = $signed(gq); ir = $signed(gr);
                    ib = $signed(W'(bi));
                    recon = W'(iq * ib + ir);
                    chk("sweep_ident", recon, ai);
                    chk("sweep_rmag", ((ir < 0 ? -ir : ir) < (ib < 0 ? -ib : ib)) ? 1 : 0, 1);
`else
                    chk("sweep_ident", int'(gq) * bi + int'(gr), ai);
                    chk("sweep_r_lt_b", (int'(gr) < bi) ? 1 : 0, 1);
`endif
                end
            end
            $display("sweep a=%0d: 256 divisors done, errors so far %0d", ai, errors);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
